// File: rtl/typecm_tx.sv
// Frame transmitter: wraps a bag type and optional payload in a sync/type/len/CRC-8 frame
// and streams it byte by byte over a valid/ready handshake.
module typecm_tx #(
  parameter logic [7:0] SYNC0 = 8'hEB,
  parameter logic [7:0] SYNC1 = 8'h90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fs_tx,
  output logic       fd_tx,
  input  logic [3:0] tx_btype,
  input  logic [7:0] data_len,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_data,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready
);

  localparam int unsigned BW = 8;
  localparam int unsigned TW = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_LATCH, S_SYNC0, S_SYNC1, S_TYPE, S_LEN, S_FETCH, S_DATA, S_CRC, S_DONE
  } state_e;

  state_e          state_q;
  logic [TW-1:0]   btype_q;
  logic [BW-1:0]   len_q;
  logic [BW-1:0]   cnt_q;
  logic [BW-1:0]   crc_q;
  logic [BW-1:0]   tx_data_q;
  logic [BW-1:0]   ram_addr_q;
  logic            tx_valid_q;
  logic            fd_tx_q;

  logic [BW-1:0]   crc_d;
  logic [BW-1:0]   cnt_nxt;
  logic            is_data;
  logic            xfer;

  // CRC-8, poly 0x07, MSB first, one byte folded into the running remainder
  function automatic logic [BW-1:0] crc8_byte(input logic [BW-1:0] crc, input logic [BW-1:0] d);
    logic [BW-1:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_d   = crc8_byte(crc_q, tx_data_q);
  assign cnt_nxt = cnt_q + 8'd1;
  assign xfer    = tx_valid_q & tx_ready;

  always_comb begin
    is_data = 1'b0;
    case (btype_q)
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE: is_data = 1'b1;
      default: is_data = 1'b0;
    endcase
  end

  // Every output is updated together with the state so it is valid for the whole state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      btype_q    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      crc_q      <= '0;
      tx_data_q  <= '0;
      ram_addr_q <= '0;
      tx_valid_q <= 1'b0;
      fd_tx_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fs_tx) state_q <= S_LATCH;
        end
        S_LATCH: begin
          btype_q    <= tx_btype;
          len_q      <= data_len;
          crc_q      <= '0;
          cnt_q      <= '0;
          ram_addr_q <= '0;
          tx_data_q  <= SYNC0;
          tx_valid_q <= 1'b1;
          state_q    <= S_SYNC0;
        end
        S_SYNC0: begin
          if (xfer) begin
            tx_data_q <= SYNC1;
            state_q   <= S_SYNC1;
          end
        end
        S_SYNC1: begin
          if (xfer) begin
            tx_data_q <= {~btype_q, btype_q};
            state_q   <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (xfer) begin
            crc_q <= crc_d;
            if (is_data) begin
              tx_data_q <= len_q;
              state_q   <= S_LEN;
            end else begin
              tx_data_q <= crc_d;
              state_q   <= S_CRC;
            end
          end
        end
        S_LEN: begin
          if (xfer) begin
            crc_q <= crc_d;
            if (len_q != '0) begin
              tx_valid_q <= 1'b0;
              ram_addr_q <= cnt_q;
              state_q    <= S_FETCH;
            end else begin
              tx_data_q <= crc_d;
              state_q   <= S_CRC;
            end
          end
        end
        // Buffer read data settles during this cycle and is captured at its end
        S_FETCH: begin
          tx_data_q  <= ram_data;
          tx_valid_q <= 1'b1;
          state_q    <= S_DATA;
        end
        S_DATA: begin
          if (xfer) begin
            crc_q <= crc_d;
            cnt_q <= cnt_nxt;
            if (cnt_nxt != len_q) begin
              tx_valid_q <= 1'b0;
              ram_addr_q <= cnt_nxt;
              state_q    <= S_FETCH;
            end else begin
              tx_data_q <= crc_d;
              state_q   <= S_CRC;
            end
          end
        end
        S_CRC: begin
          if (xfer) begin
            tx_valid_q <= 1'b0;
            fd_tx_q    <= 1'b1;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          if (!fs_tx) begin
            fd_tx_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fd_tx    = fd_tx_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign ram_addr = ram_addr_q;

endmodule

// File: tb/tb_typecm_tx.sv
// Bench for typecm_tx: frame-level model (byte queue + polynomial-division CRC) checked
// against the DUT stream on every transfer, plus directed scenarios with literal pins.
module tb_typecm_tx;

  localparam logic [7:0] S0 = 8'hEB;
  localparam logic [7:0] S1 = 8'h90;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs_tx = 1'b0;
  logic       fd_tx;
  logic [3:0] tx_btype = 4'h0;
  logic [7:0] data_len = 8'h00;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;

  logic [7:0] mem [256];
  assign ram_data = mem[ram_addr];

  typecm_tx #(.SYNC0(S0), .SYNC1(S1)) dut (
    .clk(clk), .rst(rst), .fs_tx(fs_tx), .fd_tx(fd_tx), .tx_btype(tx_btype),
    .data_len(data_len), .ram_addr(ram_addr), .ram_data(ram_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rec_q[$];
  logic [7:0] ref_q[$];
  int  byte_idx = 0;
  int  gaps = 0;
  int  exp_fetch = 0;
  int  exp_len = 0;
  bit  exp_data = 1'b0;
  bit  rand_en = 1'b0;
  bit  prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as the remainder of (message * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [8:0] r;
    r = 9'h000;
    for (int i = 0; i < msg.size(); i++) begin
      for (int b = 7; b >= 0; b--) begin
        r = {r[7:0], msg[i][b]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    for (int b = 0; b < 8; b++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  function automatic bit model_is_data(input logic [3:0] bt);
    return bt inside {4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE};
  endfunction

  task automatic expect_frame(input logic [3:0] bt, input logic [7:0] len);
    logic [7:0] body[$];
    body.delete();
    exp_q.delete();
    exp_data = model_is_data(bt);
    body.push_back({~bt, bt});
    if (exp_data) begin
      body.push_back(len);
      for (int i = 0; i < int'(len); i++) body.push_back(mem[8'(i)]);
    end
    exp_q.push_back(S0);
    exp_q.push_back(S1);
    foreach (body[i]) exp_q.push_back(body[i]);
    exp_q.push_back(model_crc(body));
    exp_fetch = exp_data ? int'(len) : 0;
    exp_len   = int'(len);
    byte_idx  = 0;
    gaps      = 0;
  endtask

  // Stream checker: every handshake against the model queue, plus hold-while-stalled
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_hold_valid", int'(tx_valid), 1);
        chk("stall_hold_data", int'(tx_data), int'(prev_data));
      end
      if (fd_tx) chk("fd_excludes_valid", int'(tx_valid), 0);
      if (tx_valid && tx_ready) begin
        rec_q.push_back(tx_data);
        if (exp_q.size() == 0) begin
          chk("extra_byte", int'(tx_valid), 0);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk($sformatf("byte%0d", byte_idx), int'(tx_data), int'(e));
          if (exp_data && byte_idx >= 4 && byte_idx < 4 + exp_len)
            chk("ram_addr", int'(ram_addr), byte_idx - 4);
          if (exp_data && exp_len == 0) chk("ram_addr_zero", int'(ram_addr), 0);
          byte_idx++;
          if (exp_q.size() == 0) chk("fetch_cycles", gaps, exp_fetch);
        end
      end else if (!tx_valid && byte_idx > 0 && exp_q.size() > 0) begin
        gaps++;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  always @(posedge clk) begin
    #1;
    tx_ready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic start(input logic [3:0] bt, input logic [7:0] len);
    expect_frame(bt, len);
    tx_btype = bt;
    data_len = len;
    fs_tx    = 1'b1;
  endtask

  task automatic wait_fd(input int bound, output int cycles);
    cycles = 0;
    while (!fd_tx && cycles < bound) begin
      cyc(1);
      cycles++;
    end
    chk("fd_tx_seen", int'(fd_tx), 1);
    chk("frame_complete", exp_q.size(), 0);
  endtask

  task automatic wait_bytes(input int n);
    int i;
    i = 0;
    while (byte_idx < n && i < 500) begin
      cyc(1);
      i++;
    end
    chk("reached_byte", int'(byte_idx >= n), 1);
  endtask

  task automatic finish_frame();
    fs_tx = 1'b0;
    cyc(1);
    chk("fd_after_release", int'(fd_tx), 0);
  endtask

  logic [3:0] tbl_t [8] = '{4'h1, 4'h0, 4'hB, 4'hF, 4'h5, 4'h8, 4'hE, 4'hA};
  logic [7:0] tbl_l [8] = '{8'd5, 8'd7, 8'd3, 8'd2, 8'd1, 8'd2, 8'd5, 8'd0};

  initial begin
    int cycles;
    logic [7:0] m[$];
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);

    // Pin the model against hand-computed CRCs
    m = '{8'hE1};
    chk("pin_crc_ack", int'(model_crc(m)), 8'hA9);
    m = '{8'h2D, 8'h00};
    chk("pin_crc_d0", int'(model_crc(m)), 8'h47);

    cyc(3);
    chk("rst_valid", int'(tx_valid), 0);
    chk("rst_fd", int'(fd_tx), 0);
    chk("rst_data", int'(tx_data), 0);
    chk("rst_addr", int'(ram_addr), 0);
    rst = 1'b0;
    cyc(2);

    // ACK: four bytes back to back, fd held until fs_tx drops
    start(4'h1, 8'd9);
    chk("ack_q_type", int'(exp_q[2]), 8'hE1);
    chk("ack_q_crc", int'(exp_q[3]), 8'hA9);
    wait_fd(50, cycles);
    chk("ack_latency", cycles, 6);
    repeat (3) begin
      cyc(1);
      chk("fd_hold", int'(fd_tx), 1);
    end
    finish_frame();

    // Zero-length data bag
    start(4'hD, 8'd0);
    chk("d0_q_crc", int'(exp_q[4]), 8'h47);
    wait_fd(50, cycles);
    chk("d0_latency", cycles, 7);
    finish_frame();

    // Four-byte payload from a known buffer
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    start(4'hE, 8'd4);
    wait_fd(100, cycles);
    chk("d4_latency", cycles, 15);
    finish_frame();

    // Classification sweep over control and data codes
    for (int k = 0; k < 8; k++) begin
      start(tbl_t[k], tbl_l[k]);
      wait_fd(200, cycles);
      finish_frame();
    end

    // Same 16-byte frame without and with random backpressure
    rec_q.delete();
    start(4'h9, 8'd16);
    wait_fd(200, cycles);
    finish_frame();
    ref_q = rec_q;
    rec_q.delete();
    rand_en = 1'b1;
    start(4'h9, 8'd16);
    wait_fd(2000, cycles);
    rand_en = 1'b0;
    finish_frame();
    chk("bp_count", rec_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < rec_q.size(); i++)
      chk($sformatf("bp_byte%0d", i), int'(rec_q[i]), int'(ref_q[i]));

    // Inputs change and fs_tx drops mid-frame: frame unchanged, fd one cycle
    start(4'h6, 8'd3);
    wait_bytes(2);
    tx_btype = 4'h1;
    data_len = 8'd200;
    fs_tx    = 1'b0;
    wait_fd(100, cycles);
    cyc(1);
    chk("fd_pulse_one", int'(fd_tx), 0);
    cyc(1);
    chk("idle_valid", int'(tx_valid), 0);

    // Longest payload, no counter wrap
    start(4'h8, 8'd255);
    wait_fd(3000, cycles);
    finish_frame();

    // Reset during payload, then a clean ACK
    start(4'h7, 8'd8);
    wait_bytes(6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", int'(tx_valid), 0);
    chk("abort_data", int'(tx_data), 0);
    chk("abort_addr", int'(ram_addr), 0);
    exp_q.delete();
    fs_tx = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_idle", int'(tx_valid), 0);
    start(4'h1, 8'd0);
    wait_fd(50, cycles);
    chk("ack2_latency", cycles, 6);
    finish_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
